// File: rtl/lb_arb2.sv
// Two-master round-robin arbiter for the register-map local bus.
// One transaction reaches the slave at a time; a response timeout completes stalled transfers.
module lb_arb2 #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT_CYC = 64,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(32'hDEADBEEF),
    localparam int               STRB_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // master 0
    input  logic [ADDR_W-1:0] m0_waddr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic              m0_wen,
    output logic              m0_wready,
    input  logic [ADDR_W-1:0] m0_raddr,
    input  logic              m0_ren,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    // master 1
    input  logic [ADDR_W-1:0] m1_waddr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wen,
    output logic              m1_wready,
    input  logic [ADDR_W-1:0] m1_raddr,
    input  logic              m1_ren,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    // slave
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid,
    // status
    output logic              err,
    output logic              busy
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_e;

    state_e          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            last_q, last_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;

    logic              req0, req1, pick, pick_wen, tmo_cyc;
    logic              wr_ack, rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] g_waddr, g_raddr;
    logic [DATA_W-1:0] g_wdata;
    logic [STRB_W-1:0] g_wstrb;

    assign req0     = m0_wen | m0_ren;
    assign req1     = m1_wen | m1_ren;
    // On a tie the master that was not granted last wins.
    assign pick     = (req0 & req1) ? ~last_q : req1;
    assign pick_wen = pick ? m1_wen : m0_wen;
    assign tmo_cyc  = (tcnt_q == TW'(TIMEOUT_CYC - 1));

    assign g_waddr = gnt_q ? m1_waddr : m0_waddr;
    assign g_wdata = gnt_q ? m1_wdata : m0_wdata;
    assign g_wstrb = gnt_q ? m1_wstrb : m0_wstrb;
    assign g_raddr = gnt_q ? m1_raddr : m0_raddr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        tcnt_d   = tcnt_q;
        lb_waddr = '0;
        lb_wdata = '0;
        lb_wstrb = '0;
        lb_wen   = 1'b0;
        lb_raddr = '0;
        lb_ren   = 1'b0;
        wr_ack   = 1'b0;
        rd_ack   = 1'b0;
        rd_data  = '0;
        err      = 1'b0;
        busy     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    tcnt_d  = '0;
                    state_d = pick_wen ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                lb_waddr = g_waddr;
                lb_wdata = g_wdata;
                lb_wstrb = g_wstrb;
                lb_wen   = ~(tmo_cyc & ~lb_wready);
                err      = tmo_cyc & ~lb_wready;
                wr_ack   = lb_wready | tmo_cyc;
                if (wr_ack) state_d = S_IDLE;
                else        tcnt_d  = tcnt_q + TW'(1);
            end
            S_READ: begin
                busy     = 1'b1;
                lb_raddr = g_raddr;
                lb_ren   = ~(tmo_cyc & ~lb_rvalid);
                err      = tmo_cyc & ~lb_rvalid;
                rd_ack   = lb_rvalid | tmo_cyc;
                rd_data  = lb_rvalid ? lb_rdata : ERR_DATA;
                if (rd_ack) state_d = S_IDLE;
                else        tcnt_d  = tcnt_q + TW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m0_wready = wr_ack & ~gnt_q;
    assign m1_wready = wr_ack &  gnt_q;
    assign m0_rvalid = rd_ack & ~gnt_q;
    assign m1_rvalid = rd_ack &  gnt_q;
    assign m0_rdata  = (rd_ack & ~gnt_q) ? rd_data : '0;
    assign m1_rdata  = (rd_ack &  gnt_q) ? rd_data : '0;

endmodule

// File: tb/tb_lb_arb2.sv
// Self-checking bench for lb_arb2: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration and timeout rules.
module tb_lb_arb2;

    localparam int          AW   = 16;
    localparam int          DW   = 32;
    localparam int          SW   = 4;
    localparam int          TO   = 64;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;

    logic [AW-1:0] mwaddr [2];
    logic [AW-1:0] mraddr [2];
    logic [DW-1:0] mwdata [2];
    logic [SW-1:0] mwstrb [2];
    logic          mwen   [2];
    logic          mren   [2];

    logic          m0_wready, m1_wready, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] lb_waddr, lb_raddr;
    logic [DW-1:0] lb_wdata, lb_rdata;
    logic [SW-1:0] lb_wstrb;
    logic          lb_wen, lb_ren, lb_wready, lb_rvalid, err, busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lb_arb2 dut (
        .clk       (clk),
        .rst       (rst),
        .m0_waddr  (mwaddr[0]),
        .m0_wdata  (mwdata[0]),
        .m0_wstrb  (mwstrb[0]),
        .m0_wen    (mwen[0]),
        .m0_wready (m0_wready),
        .m0_raddr  (mraddr[0]),
        .m0_ren    (mren[0]),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m1_waddr  (mwaddr[1]),
        .m1_wdata  (mwdata[1]),
        .m1_wstrb  (mwstrb[1]),
        .m1_wen    (mwen[1]),
        .m1_wready (m1_wready),
        .m1_raddr  (mraddr[1]),
        .m1_ren    (mren[1]),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .lb_waddr  (lb_waddr),
        .lb_wdata  (lb_wdata),
        .lb_wstrb  (lb_wstrb),
        .lb_wen    (lb_wen),
        .lb_wready (lb_wready),
        .lb_raddr  (lb_raddr),
        .lb_ren    (lb_ren),
        .lb_rdata  (lb_rdata),
        .lb_rvalid (lb_rvalid),
        .err       (err),
        .busy      (busy)
    );

    task automatic clear_inputs();
        for (int m = 0; m < 2; m++) begin
            mwaddr[m] = '0; mraddr[m] = '0; mwdata[m] = '0; mwstrb[m] = '0;
            mwen[m]   = 1'b0; mren[m] = 1'b0;
        end
        lb_wready = 1'b0; lb_rvalid = 1'b0; lb_rdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        mwen[0] = 1'b1; mwaddr[0] = 16'h12;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if ({lb_wen, lb_ren, lb_waddr, lb_wdata, lb_wstrb, lb_raddr, m0_wready, m0_rvalid, m0_rdata,
             m1_wready, m1_rvalid, m1_rdata, err, busy} !== '0)
            $display("FAIL reset_outputs: got wen=%0b ren=%0b waddr=%h busy=%0b err=%0b, want all 0",
                     lb_wen, lb_ren, lb_waddr, busy, err);
        else n_pass++;
        @(negedge clk);
        mwen[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        n_chk++;
        if ({lb_wen, lb_ren, busy} !== 3'b000)
            $display("FAIL reset_idle: got wen/ren/busy=%b, want 000", {lb_wen, lb_ren, busy});
        else n_pass++;
    endtask

    task automatic test_single_write();
        apply_reset();
        @(negedge clk);
        mwen[0] = 1'b1; mwaddr[0] = 16'h50; mwdata[0] = 32'h1; mwstrb[0] = 4'hF;
        #1;
        n_chk++;
        if ({lb_wen, busy} !== 2'b00)
            $display("FAIL wr_grant_cycle: got wen/busy=%b, want 00", {lb_wen, busy});
        else n_pass++;
        @(negedge clk);
        lb_wready = 1'b1;
        #1;
        n_chk++;
        if ({lb_wen, lb_waddr, lb_wdata, lb_wstrb} !== {1'b1, 16'h50, 32'h1, 4'hF})
            $display("FAIL wr_lb_req: got wen=%0b addr=%h data=%h strb=%h, want 1/0050/00000001/f",
                     lb_wen, lb_waddr, lb_wdata, lb_wstrb);
        else n_pass++;
        n_chk++;
        if ({m0_wready, m1_wready, err, busy} !== 4'b1001)
            $display("FAIL wr_ready: got m0w/m1w/err/busy=%b, want 1001", {m0_wready, m1_wready, err, busy});
        else n_pass++;
        @(negedge clk);
        lb_wready = 1'b0; mwen[0] = 1'b0;
        #1;
        n_chk++;
        if ({lb_wen, busy, m0_wready} !== 3'b000)
            $display("FAIL wr_done_idle: got wen/busy/m0w=%b, want 000", {lb_wen, busy, m0_wready});
        else n_pass++;
    endtask

    task automatic test_single_read();
        apply_reset();
        @(negedge clk);
        mren[1] = 1'b1; mraddr[1] = 16'h50;
        @(negedge clk);
        lb_rvalid = 1'b1; lb_rdata = 32'h3;
        #1;
        n_chk++;
        if ({lb_ren, lb_raddr, m1_rvalid, m1_rdata} !== {1'b1, 16'h50, 1'b1, 32'h3})
            $display("FAIL rd_m1: got ren=%0b addr=%h rvalid=%0b rdata=%h, want 1/0050/1/00000003",
                     lb_ren, lb_raddr, m1_rvalid, m1_rdata);
        else n_pass++;
        n_chk++;
        if ({m0_rvalid, m0_rdata, lb_wen, err} !== '0)
            $display("FAIL rd_m0_quiet: got m0_rvalid=%0b m0_rdata=%h wen=%0b err=%0b, want 0",
                     m0_rvalid, m0_rdata, lb_wen, err);
        else n_pass++;
        @(negedge clk);
        lb_rvalid = 1'b0; mren[1] = 1'b0;
    endtask

    task automatic test_contention();
        apply_reset();
        @(negedge clk);
        mwen[0] = 1'b1; mwaddr[0] = 16'h10; mwdata[0] = 32'hA0; mwstrb[0] = 4'h3;
        mwen[1] = 1'b1; mwaddr[1] = 16'h20; mwdata[1] = 32'hB1; mwstrb[1] = 4'hC;
        for (int t = 0; t < 4; t++) begin
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            ea = (t % 2 == 0) ? 16'h10 : 16'h20;
            ed = (t % 2 == 0) ? 32'hA0 : 32'hB1;
            #1;
            n_chk++;
            if (busy !== 1'b0) $display("FAIL cont_idle_gap%0d: got busy=%0b, want 0", t, busy);
            else n_pass++;
            @(negedge clk);
            lb_wready = 1'b1;
            #1;
            n_chk++;
            if ({lb_wen, lb_waddr, lb_wdata, m0_wready, m1_wready} !==
                {1'b1, ea, ed, (t % 2 == 0), (t % 2 == 1)})
                $display("FAIL cont_order%0d: got addr=%h data=%h m0w=%0b m1w=%0b, want addr=%h data=%h",
                         t, lb_waddr, lb_wdata, m0_wready, m1_wready, ea, ed);
            else n_pass++;
            @(negedge clk);
            lb_wready = 1'b0;
        end
        mwen[0] = 1'b0; mwen[1] = 1'b0;
    endtask

    task automatic test_same_master();
        apply_reset();
        @(negedge clk);
        mwen[0] = 1'b1; mwaddr[0] = 16'h30; mwdata[0] = 32'h55; mwstrb[0] = 4'h1;
        mren[0] = 1'b1; mraddr[0] = 16'h34;
        @(negedge clk);
        lb_wready = 1'b1;
        #1;
        n_chk++;
        if ({lb_wen, lb_ren, lb_waddr, m0_wready, m0_rvalid} !== {2'b10, 16'h30, 2'b10})
            $display("FAIL same_write_first: got wen=%0b ren=%0b addr=%h m0w=%0b m0r=%0b, want 1/0/0030/1/0",
                     lb_wen, lb_ren, lb_waddr, m0_wready, m0_rvalid);
        else n_pass++;
        @(negedge clk);
        lb_wready = 1'b0; mwen[0] = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL same_idle_gap: got busy=%0b, want 0", busy);
        else n_pass++;
        @(negedge clk);
        lb_rvalid = 1'b1; lb_rdata = 32'hA5;
        #1;
        n_chk++;
        if ({lb_ren, lb_raddr, m0_rvalid, m0_rdata, m0_wready} !== {1'b1, 16'h34, 1'b1, 32'hA5, 1'b0})
            $display("FAIL same_read_second: got ren=%0b addr=%h m0r=%0b rdata=%h, want 1/0034/1/000000a5",
                     lb_ren, lb_raddr, m0_rvalid, m0_rdata);
        else n_pass++;
        @(negedge clk);
        lb_rvalid = 1'b0; mren[0] = 1'b0;
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        apply_reset();
        @(negedge clk);
        mren[0] = 1'b1; mraddr[0] = 16'h44;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk); #1;
            if (k < TO) begin
                if ({lb_ren, m0_rvalid, err, busy} !== 4'b1001) bad++;
            end else begin
                n_chk++;
                if ({lb_ren, m0_rvalid, m0_rdata, m1_rvalid, err, busy} !== {2'b01, ERRD, 3'b011})
                    $display("FAIL tmo_fire: got ren=%0b rvalid=%0b rdata=%h err=%0b, want 0/1/deadbeef/1",
                             lb_ren, m0_rvalid, m0_rdata, err);
                else n_pass++;
            end
        end
        n_chk++;
        if (bad != 0) $display("FAIL tmo_wait: got %0d bad waiting cycles, want 0", bad);
        else n_pass++;
        @(negedge clk);
        mren[0] = 1'b0;
        mwen[1] = 1'b1; mwaddr[1] = 16'h60; mwdata[1] = 32'h66; mwstrb[1] = 4'hF;
        #1;
        n_chk++;
        if ({err, busy} !== 2'b00) $display("FAIL tmo_after: got err/busy=%b, want 00", {err, busy});
        else n_pass++;
        @(negedge clk);
        lb_wready = 1'b1;
        #1;
        n_chk++;
        if ({lb_wen, lb_waddr, m1_wready, err} !== {1'b1, 16'h60, 1'b1, 1'b0})
            $display("FAIL tmo_next_write: got wen=%0b addr=%h m1w=%0b err=%0b, want 1/0060/1/0",
                     lb_wen, lb_waddr, m1_wready, err);
        else n_pass++;
        @(negedge clk);
        lb_wready = 1'b0; mwen[1] = 1'b0;
        mren[1] = 1'b1; mraddr[1] = 16'h61;
        repeat (TO) @(negedge clk);
        lb_rvalid = 1'b1; lb_rdata = 32'h77;
        #1;
        n_chk++;
        if ({m1_rvalid, m1_rdata, err, lb_ren} !== {1'b1, 32'h77, 1'b0, 1'b1})
            $display("FAIL tmo_slave_wins: got rvalid=%0b rdata=%h err=%0b ren=%0b, want 1/00000077/0/1",
                     m1_rvalid, m1_rdata, err, lb_ren);
        else n_pass++;
        @(negedge clk);
        lb_rvalid = 1'b0; mren[1] = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        @(negedge clk);
        mwen[0] = 1'b1; mwaddr[0] = 16'h70; mwdata[0] = 32'h7; mwstrb[0] = 4'hF;
        @(negedge clk); #1;
        n_chk++;
        if ({lb_wen, busy} !== 2'b11) $display("FAIL rstmid_in_write: got wen/busy=%b, want 11", {lb_wen, busy});
        else n_pass++;
        lb_wready = 1'b1;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({lb_wen, lb_ren, busy, m0_wready, m1_wready, m0_rvalid, m1_rvalid, err} !== 8'h00)
            $display("FAIL rstmid_async: got wen/ren/busy/m0w/m1w/m0r/m1r/err=%b, want 0",
                     {lb_wen, lb_ren, busy, m0_wready, m1_wready, m0_rvalid, m1_rvalid, err});
        else n_pass++;
        @(negedge clk);
        lb_wready = 1'b0;
        mwen[1] = 1'b1; mwaddr[1] = 16'h71; mwdata[1] = 32'h8; mwstrb[1] = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        lb_wready = 1'b1;
        #1;
        n_chk++;
        if ({lb_wen, lb_waddr, m0_wready, m1_wready} !== {1'b1, 16'h70, 2'b10})
            $display("FAIL rstmid_first_tie: got wen=%0b addr=%h m0w=%0b m1w=%0b, want 1/0070/1/0",
                     lb_wen, lb_waddr, m0_wready, m1_wready);
        else n_pass++;
        @(negedge clk);
        lb_wready = 1'b0;
        clear_inputs();
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 15);
        if (r < 12) return r % 4;
        if (r == 12) return TO - 1;
        if (r == 13) return TO - 2;
        return 255;
    endfunction

    // The model tracks the transaction in flight (owner, direction, age) and applies the
    // grant, completion and timeout rules directly to the stimulus seen each cycle.
    task automatic test_random();
        bit            act, cw, resp, tmo, done, r0, r1;
        int            cm, age, last, scnt, slat, op;
        bit            seen_w [2];
        bit            seen_r [2];
        logic [7:0]    exp_ctl, got_ctl;
        logic [DW-1:0] e0, e1;
        apply_reset();
        act = 0; cw = 0; cm = 0; age = 0; last = 1; scnt = 0; slat = pick_lat();
        seen_w[0] = 0; seen_w[1] = 0; seen_r[0] = 0; seen_r[1] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (seen_w[m]) mwen[m] = 1'b0;
                if (seen_r[m]) mren[m] = 1'b0;
                if (!mwen[m] && !mren[m] && $urandom_range(0, 2) == 0) begin
                    op        = $urandom_range(0, 5);
                    mwen[m]   = (op <= 2) || (op == 5);
                    mren[m]   = (op >= 3);
                    mwaddr[m] = AW'($urandom);
                    mraddr[m] = AW'($urandom);
                    mwdata[m] = $urandom;
                    mwstrb[m] = SW'($urandom);
                end
            end
            lb_wready = 1'b0; lb_rvalid = 1'b0; lb_rdata = $urandom;
            #1;
            if (busy) begin
                if (scnt == slat) begin lb_wready = 1'b1; lb_rvalid = 1'b1; end
            end else if ($urandom_range(0, 7) == 0) begin
                lb_wready = 1'($urandom_range(0, 1));
                lb_rvalid = 1'($urandom_range(0, 1));
            end
            #1;

            resp = act && (cw ? lb_wready : lb_rvalid);
            tmo  = act && !resp && (age == TO - 1);
            done = resp || tmo;
            exp_ctl = {act && cw && !tmo, act && !cw && !tmo,
                       act && cw && done && cm == 0, act && cw && done && cm == 1,
                       act && !cw && done && cm == 0, act && !cw && done && cm == 1, tmo, act};
            got_ctl = {lb_wen, lb_ren, m0_wready, m1_wready, m0_rvalid, m1_rvalid, err, busy};
            e0 = (act && !cw && done && cm == 0) ? (resp ? lb_rdata : ERRD) : '0;
            e1 = (act && !cw && done && cm == 1) ? (resp ? lb_rdata : ERRD) : '0;
            n_chk++;
            if ({got_ctl, m0_rdata, m1_rdata} !== {exp_ctl, e0, e1})
                $display("FAIL rand_ctl cyc%0d: got ctl=%b rd0=%h rd1=%h, want ctl=%b rd0=%h rd1=%h",
                         cyc, got_ctl, m0_rdata, m1_rdata, exp_ctl, e0, e1);
            else n_pass++;
            if (act) begin
                n_chk++;
                if (cw ? ({lb_waddr, lb_wdata, lb_wstrb} !== {mwaddr[cm], mwdata[cm], mwstrb[cm]})
                       : (lb_raddr !== mraddr[cm]))
                    $display("FAIL rand_mux cyc%0d: got waddr=%h raddr=%h, want master %0d (w=%0b) waddr=%h raddr=%h",
                             cyc, lb_waddr, lb_raddr, cm, cw, mwaddr[cm], mraddr[cm]);
                else n_pass++;
            end

            seen_w[0] = m0_wready; seen_w[1] = m1_wready;
            seen_r[0] = m0_rvalid; seen_r[1] = m1_rvalid;
            if (busy) begin
                if (scnt == slat) begin scnt = 0; slat = pick_lat(); end
                else scnt++;
            end else begin
                if (scnt != 0) slat = pick_lat();
                scnt = 0;
            end

            if (act) begin
                if (done) act = 0;
                else      age++;
            end else begin
                r0 = mwen[0] || mren[0];
                r1 = mwen[1] || mren[1];
                if (r0 || r1) begin
                    cm   = (r0 && r1) ? 1 - last : (r1 ? 1 : 0);
                    cw   = mwen[cm];
                    act  = 1;
                    age  = 0;
                    last = cm;
                end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_same_master();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lb_arb2.md
# lb_arb2

Two-master arbiter for the register-map local bus (LB). Lets two LB masters, e.g. the APB-to-LB bridge and an on-chip sequencer, share one register-map slave port. Only one transaction is on the slave at a time, and masters are granted round-robin. A response timeout keeps a dead slave from stalling either master.

## Interface
- ADDR_W, 16, LB address width
- DATA_W, 32, LB data width, multiple of 8
- STRB_W, DATA_W/8, byte-strobe width (derived, not overridden)
- TIMEOUT_CYC, 64, cycles in WRITE/READ before forced completion, ≥2
- ERR_DATA, 'hDEADBEEF (truncated to DATA_W), read data returned on timeout
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- mN_waddr / mN_wdata / mN_wstrb / mN_wen  in  ADDR_W / DATA_W / STRB_W / 1  master N write request, N∈{0,1}
- mN_wready  out  1  write completion to master N
- mN_raddr / mN_ren  in  ADDR_W / 1  master N read request
- mN_rdata / mN_rvalid  out  DATA_W / 1  read response to master N
- lb_waddr / lb_wdata / lb_wstrb / lb_wen  out  ADDR_W / DATA_W / STRB_W / 1  slave write request
- lb_wready  in  1  slave write completion
- lb_raddr / lb_ren  out  ADDR_W / 1  slave read request
- lb_rdata / lb_rvalid  in  DATA_W / 1  slave read response
- err  out  1  one-cycle pulse on timeout completion
- busy  out  1  high in WRITE or READ

## Operation
- Master protocol: assert wen or ren with stable address, data and strobe, and hold until own wready or rvalid is seen high at a rising edge. Drop or change the request the cycle after.
- FSM states: IDLE, WRITE, READ. Registers: state, gnt (0/1), last (0/1), tcnt.
- IDLE: requester set is {N : mN_wen|mN_ren}.
  - Empty set: stay in IDLE.
  - One requester: grant it.
  - Both: grant !last.
  - On grant: gnt<=N, last<=N, tcnt<=0. Next state is WRITE if mN_wen, else READ; write wins if the same master asserts both.
- WRITE/READ: lb_* request outputs mux the granted master's inputs. The non-granted master's request is ignored and held off.
- Completion in WRITE: lb_wready=1. mgnt_wready=lb_wready in the same cycle, then state<=IDLE.
- Completion in READ: lb_rvalid=1. mgnt_rvalid=1 and mgnt_rdata=lb_rdata in the same cycle, then state<=IDLE.
- Timeout:
  - tcnt increments each WRITE/READ cycle without completion.
  - If tcnt==TIMEOUT_CYC-1 and there is no slave response, the arbiter completes the transaction itself: mgnt_wready=1 or mgnt_rvalid=1 with rdata=ERR_DATA, err=1, and lb_wen/lb_ren are forced 0 that cycle. Then state<=IDLE.
  - A slave response on the timeout cycle takes precedence: normal completion, err=0.
- Slave responses are ignored when not in the matching state: lb_wready outside WRITE, lb_rvalid outside READ.
- Non-granted master outputs: wready=0, rvalid=0, rdata=0.
- tcnt width: $clog2(TIMEOUT_CYC). No wrap, since it is cleared on every grant.

## Timing
- Reset values: state=IDLE, gnt=0, last=1 (m0 wins the first tie), tcnt=0. All outputs 0: lb_wen, lb_ren, lb_waddr, lb_wdata, lb_wstrb, lb_raddr, mN_wready, mN_rvalid, mN_rdata, err, busy.
- lb_wen/lb_ren are asserted from the cycle after the grant edge. Minimum transaction is 2 cycles: IDLE grant, then a 1-cycle slave response.
- Master response is combinational from the slave response, with zero added latency.
- At least one IDLE cycle between transactions. Back-to-back requests from both masters alternate m0, m1, m0 and so on.
- Reset asserted mid-transaction: everything returns to reset values immediately. Any slave response after that is ignored.
- err is high for exactly one cycle and coincides with the forced ready/valid.

## Test plan
- Single write: m0 writes addr 'h50, data 1, strb 'hF, and the slave answers wready 1 cycle after lb_wen. Required: lb_wen high 1 cycle with lb_waddr='h50, m0_wready high the same cycle, m1_wready=0, err=0.
- Single read: m1 reads 'h50 and the slave returns 'h3. Required: m1_rvalid=1 with m1_rdata='h3 in the lb_rvalid cycle; m0_rvalid=0.
- Contention: m0 and m1 both request continuously for 4 transactions. Required: grant order m0, m1, m0, m1, each separated by one IDLE cycle; the held-off master sees no lb_* traffic.
- Same-master write+read: m0 asserts wen and ren together. Required: write completes first, then the read is granted. If m1 is idle, that is m0 again, after one IDLE cycle.
- Timeout: the slave never answers a read from m0 with TIMEOUT_CYC=64. Required: on the 64th READ cycle, m0_rvalid=1, m0_rdata='hDEADBEEF, err=1 for one cycle, then IDLE. A following m1 write completes normally.
- Reset mid-write: drop rst while in WRITE. Required: lb_wen, busy and all ready/valid outputs go to 0 without a clock edge; after release, the first tie is granted to m0.
